// File: rtl/tagged_reg_file.sv
// tagged_reg_file: tag-tracking field register file for the out-of-order core.
//
// Each field holds a value, a valid bit and the reservation-station tag that will
// produce it. Dispatch retags fields through the update port, execution units
// broadcast results on WRITE_PORTS result buses, and an architectural direct-write
// path and a misprediction flush are provided. Per-field priority is
// rst > flush > update > direct > result.
//
// Optional feature macro: TAGGED_REG_FILE_BYPASS_EN
//   When defined, read_value_valid/read_value combinationally show result writes
//   accepted in the current cycle (fields without a same-cycle update).
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   rst              synchronous active-low reset
//   read_value_valid per-field valid bits
//   read_value       packed field values, field 0 in the most significant slice
//   read_rs_id       producing tag per field
//   pending_count    registered count of fields with valid=0
//   write_enable     per-port, per-field result strobes
//   write_value      per-port result data (same packing as read_value)
//   write_rs_id      per-port broadcasting tag
//   update_enable    per-field invalidate-and-retag strobes
//   update_rs_id     new tag for updated fields
//   direct_enable    per-field architectural write strobes
//   direct_value     data for direct writes (same packing as read_value)
//   flush            misprediction recovery: mark every field valid
module tagged_reg_file #(
    parameter int unsigned FIELD_COUNT = 8,
    parameter int unsigned FIELD_WIDTH = 4,
    parameter int unsigned RS_ID_WIDTH = 5,
    parameter int unsigned WRITE_PORTS = 2,
    localparam int unsigned CountWidth = $clog2(FIELD_COUNT + 1)
) (
    input  logic                                                clk,
    input  logic                                                rst,
    output logic [FIELD_COUNT-1:0]                              read_value_valid,
    output logic [FIELD_COUNT*FIELD_WIDTH-1:0]                  read_value,
    output logic [FIELD_COUNT-1:0][RS_ID_WIDTH-1:0]             read_rs_id,
    output logic [CountWidth-1:0]                               pending_count,
    input  logic [WRITE_PORTS-1:0][FIELD_COUNT-1:0]             write_enable,
    input  logic [WRITE_PORTS-1:0][FIELD_COUNT*FIELD_WIDTH-1:0] write_value,
    input  logic [WRITE_PORTS-1:0][RS_ID_WIDTH-1:0]             write_rs_id,
    input  logic [FIELD_COUNT-1:0]                              update_enable,
    input  logic [RS_ID_WIDTH-1:0]                              update_rs_id,
    input  logic [FIELD_COUNT-1:0]                              direct_enable,
    input  logic [FIELD_COUNT*FIELD_WIDTH-1:0]                  direct_value,
    input  logic                                                flush
);

    logic [FIELD_COUNT-1:0][FIELD_WIDTH-1:0] value_q, value_d;
    logic [FIELD_COUNT-1:0]                  valid_q, valid_d;
    logic [FIELD_COUNT-1:0][RS_ID_WIDTH-1:0] rs_id_q, rs_id_d;
    logic [CountWidth-1:0]                   pending_q, pending_d;

    // Accepted result per field (after lowest-port arbitration) and its data.
    logic [FIELD_COUNT-1:0]                  res_hit;
    logic [FIELD_COUNT-1:0][FIELD_WIDTH-1:0] res_val;
    // Update strobes that survive a same-cycle flush.
    logic [FIELD_COUNT-1:0]                  upd_eff;

    always_comb begin
        res_hit = '0;
        res_val = '0;
        upd_eff = '0;
        for (int f = 0; f < int'(FIELD_COUNT); f++) begin
            // Field 0 occupies the most significant slice of the packed buses.
            int lo;
            lo = (int'(FIELD_COUNT) - 1 - f) * int'(FIELD_WIDTH);
            // Walk ports from highest to lowest so the lowest accepting port wins.
            for (int p = int'(WRITE_PORTS) - 1; p >= 0; p--) begin
                if (write_enable[p][f] && !valid_q[f] && (rs_id_q[f] == write_rs_id[p])) begin
                    res_hit[f] = 1'b1;
                    res_val[f] = write_value[p][lo +: FIELD_WIDTH];
                end
            end
            upd_eff[f] = update_enable[f] & ~flush;
        end
    end

    always_comb begin
        value_d   = value_q;
        valid_d   = valid_q;
        rs_id_d   = rs_id_q;
        pending_d = '0;
        for (int f = 0; f < int'(FIELD_COUNT); f++) begin
            int lo;
            lo = (int'(FIELD_COUNT) - 1 - f) * int'(FIELD_WIDTH);
            // Values: direct write overrides result; update and flush never block data.
            if (direct_enable[f]) begin
                value_d[f] = direct_value[lo +: FIELD_WIDTH];
            end else if (res_hit[f]) begin
                value_d[f] = res_val[f];
            end
            // Valid and tag: flush > update > direct/result.
            if (flush) begin
                valid_d[f] = 1'b1;
            end else if (upd_eff[f]) begin
                valid_d[f] = 1'b0;
                rs_id_d[f] = update_rs_id;
            end else if (direct_enable[f] || res_hit[f]) begin
                valid_d[f] = 1'b1;
            end
            if (!valid_d[f]) begin
                pending_d = pending_d + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            value_q   <= '0;
            valid_q   <= '1;
            rs_id_q   <= '0;
            pending_q <= '0;
        end else begin
            value_q   <= value_d;
            valid_q   <= valid_d;
            rs_id_q   <= rs_id_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        read_value_valid = valid_q;
        read_value       = '0;
        for (int f = 0; f < int'(FIELD_COUNT); f++) begin
            int lo;
            lo = (int'(FIELD_COUNT) - 1 - f) * int'(FIELD_WIDTH);
            read_value[lo +: FIELD_WIDTH] = value_q[f];
`ifdef TAGGED_REG_FILE_BYPASS_EN
            // Forward results accepted this cycle unless the field is being retagged.
            if (rst && res_hit[f] && !upd_eff[f]) begin
                read_value_valid[f]           = 1'b1;
                read_value[lo +: FIELD_WIDTH] = res_val[f];
            end
`endif
        end
    end

    assign read_rs_id    = rs_id_q;
    assign pending_count = pending_q;

endmodule
